mips_instruction_fetch_mem: RTL and testbench
=============================================

// Module: mips_instruction_fetch_mem
// PURPOSE
//  Parametrised instruction memory for the MIPS fetch stage. Replaces the combinational ROM with
//  a registered (BRAM-inferable) read behind a valid/ready request/response handshake.
//  Adds programmable wait states, a response hold buffer for back-pressure, flush, and fault
//  reporting. Sits between the PC/fetch unit and the decode stage.
// PARAMETERS
//  DEPTH        256                 words of instruction storage; power of two, >=2
//  WAIT_STATES  0                   extra cycles per access, 0..15 (0 = 1-cycle latency)
//  INIT_FILE    Instruction_Mem_init  $readmemb image loaded at elaboration
// PORTS
//  clk        in   1   single clock, all logic on rising edge
//  rst_n      in   1   synchronous, active-low reset
//  req_valid  in   1   fetch request present
//  req_ready  out  1   block accepts request this cycle
//  req_addr   in   32  byte address of instruction
//  flush      in   1   discard in-flight/held response (branch redirect)
//  rsp_valid  out  1   response held on rsp_* outputs
//  rsp_ready  in   1   consumer takes response this cycle
//  rsp_instr  out  32  instruction word (Instruction_Width)
//  rsp_addr   out  32  byte address the response belongs to
//  rsp_fault  out  2   00 ok, 01 misaligned, 10 out of range
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, cnt=0; rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_fault=0.
//    Reset mid-access abandons it; no response is ever produced for a pre-reset request.
//  - Accept = req_valid & req_ready. Word index = req_addr[$clog2(DEPTH)+1:2], registered on accept.
//  - FSM states:
//    IDLE: req_ready = ~flush. On accept: WAIT_STATES==0 -> RESP, else WAIT with cnt=WAIT_STATES-1.
//    WAIT: req_ready=0; cnt decrements; at cnt==0 -> RESP.
//    RESP: rsp_valid=1; rsp_* stable until rsp_ready=1. req_ready = rsp_ready & ~flush.
//          rsp_ready & accept -> new access (RESP or WAIT as in IDLE); rsp_ready only -> IDLE.
//  - Latency accept->rsp_valid = 1+WAIT_STATES cycles. WAIT_STATES=0 sustains 1 fetch/cycle
//    with rsp_ready held high.
//  - ROM array read is synchronous (registered output); no combinational addr->data path.
//  - Fault: req_addr[1:0]!=0 -> 01; else req_addr[31:2] >= DEPTH -> 10; misaligned wins.
//    Faulted responses carry rsp_instr=32'h0000_0000 (NOP), same latency and handshake.
//  - Flush (priority over everything except reset): next cycle state IDLE, rsp_valid=0, cnt=0;
//    request presented in a flush cycle is not accepted (req_ready=0). rsp_instr/addr/fault
//    keep last value (don't-care while rsp_valid=0).
//  - rsp_valid never drops without rsp_ready or flush; rsp_* never change while rsp_valid&~rsp_ready.
// STRUCTURE
//  - Shared package MIPS_Generic_Definitions: Instruction_Width, Instruction_Mem_Init, new
//    typedef fetch_fault_e {FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10},
//    localparam MIPS_NOP = 32'h0. FSM state enum local to module.
//  - One sub-module: mips_sync_rom (DEPTH x Instruction_Width, registered read, en input,
//    INIT_FILE) so the array maps to block RAM; FSM, counter and fault logic in this module.
// TESTING
//  1. Reset: hold rst_n=0 3 cycles with req_valid=1 -> rsp_valid=0, rsp_*=0, no accept seen.
//  2. WAIT_STATES=0, rsp_ready=1, addrs 0x0,0x4,0x8 back-to-back -> rsp_valid each cycle from
//     cycle+1, rsp_instr = image words 0,1,2, rsp_addr matches, rsp_fault=00.
//  3. WAIT_STATES=3, req 0x10 -> rsp_valid asserted exactly 4 cycles after accept, word 4;
//     req_ready=0 during the 3 WAIT cycles.
//  4. Back-pressure: rsp_ready=0 for 5 cycles on response to 0x20 -> rsp_* stable, req_ready=0;
//     rsp_ready=1 with req 0x24 -> hand-off and accept same cycle, word 9 next cycle.
//  5. Faults, DEPTH=256: 0x6 -> 01 instr 0; 0x400 -> 10 instr 0; 0x402 -> 01 (priority).
//  6. Flush in WAIT and in held RESP -> rsp_valid=0 next cycle, IDLE; flush with req_valid=1 ->
//     req_ready=0, no response generated; rst_n=0 during WAIT -> no stale response after reset.

Source files
------------

// File: rtl/mips_instruction_fetch_mem_pkg.sv
// Shared MIPS definitions for the fetch-side instruction memory: widths, fault codes and the
// boot image generator used by the ROM.
package MIPS_Generic_Definitions;

  localparam int Instruction_Width = 32;
  localparam logic [Instruction_Width-1:0] MIPS_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fetch_fault_e;

  // Boot image: word i = 0x2000_0000 | {i[15:0], i[15:0]}, elaborated as a constant ROM so no
  // external image file is needed.
  function automatic logic [Instruction_Width-1:0] rom_word(input logic [31:0] idx);
    return 32'h2000_0000 | {idx[15:0], idx[15:0]};
  endfunction

endpackage

// File: rtl/mips_instruction_fetch_mem_if.sv
// Fetch request/response channel between the PC unit (master) and instruction memory (slave).
interface mips_instruction_fetch_mem_if;
  import MIPS_Generic_Definitions::*;

  logic                         req_valid;
  logic                         req_ready;
  logic [31:0]                  req_addr;
  logic                         flush;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [Instruction_Width-1:0] rsp_instr;
  logic [31:0]                  rsp_addr;
  fetch_fault_e                 rsp_fault;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/mips_sync_rom.sv
// Registered-read instruction ROM; the output register only loads on en so it maps to block RAM.
module mips_sync_rom
  import MIPS_Generic_Definitions::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [$clog2(DEPTH)-1:0]     addr,
  output logic [Instruction_Width-1:0] rdata
);

  always_ff @(posedge clk) begin
    if (en) rdata <= rom_word(32'(addr));
  end

endmodule

// File: rtl/mips_instruction_fetch_mem.sv
// Fetch-stage instruction memory: valid/ready request, programmable wait states, held response
// under back-pressure, flush on redirect and misalign/range fault reporting.
module mips_instruction_fetch_mem
  import MIPS_Generic_Definitions::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mips_instruction_fetch_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e                       state_q, state_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic                         accept;
  logic                         instr_ok_q;
  logic [31:0]                  addr_q;
  fetch_fault_e                 fault_q, fault_d;
  logic [Instruction_Width-1:0] rom_data;

  // Misalignment outranks range so a bad low address never reads as a valid far word.
  always_comb begin
    fault_d = FAULT_NONE;
    if (bus.req_addr[1:0] != 2'b00)                      fault_d = FAULT_MISALIGN;
    else if ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH))  fault_d = FAULT_RANGE;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.req_ready = 1'b0;
    accept        = 1'b0;
    case (state_q)
      ST_IDLE: bus.req_ready = ~bus.flush;
      ST_RESP: bus.req_ready = bus.rsp_ready & ~bus.flush;
      default: bus.req_ready = 1'b0;
    endcase
    accept = bus.req_valid & bus.req_ready;

    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          cnt_d   = CNT_INIT;
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_d = ST_RESP;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_RESP: if (bus.rsp_ready) begin
          if (accept) begin
            state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      fault_q    <= FAULT_NONE;
      instr_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q     <= bus.req_addr;
        fault_q    <= fault_d;
        instr_ok_q <= (fault_d == FAULT_NONE);
      end
    end
  end

  mips_sync_rom #(.DEPTH(DEPTH)) u_rom (
    .clk   (clk),
    .en    (accept & rst_n),
    .addr  (bus.req_addr[AW+1:2]),
    .rdata (rom_data)
  );

  // ROM output only reloads on accept, so the held response stays stable under back-pressure.
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_instr = instr_ok_q ? rom_data : MIPS_NOP;
  assign bus.rsp_addr  = addr_q;
  assign bus.rsp_fault = fault_q;

endmodule

// File: tb/tb_mips_instruction_fetch_mem.sv
// Directed bench: one 0-wait-state and one 3-wait-state instance on a shared clock and reset.
module tb_mips_instruction_fetch_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cmp = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  mips_instruction_fetch_mem_if f0();
  mips_instruction_fetch_mem_if f3();

  mips_instruction_fetch_mem #(.DEPTH(256), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(f0));
  mips_instruction_fetch_mem #(.DEPTH(256), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(f3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f0.req_valid = 1'b1; f0.req_addr = 32'h4;
    f3.req_valid = 1'b1; f3.req_addr = 32'h8;
    for (int c = 0; c < 3; c++) begin
      step();
      cmp++; if (f0.rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid0[%0d]: got %b want 0", c, f0.rsp_valid); end
      cmp++; if (f3.rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid3[%0d]: got %b want 0", c, f3.rsp_valid); end
      cmp++; if (f0.rsp_instr !== 32'h0 || f0.rsp_addr !== 32'h0 || f0.rsp_fault !== 2'b00)
        begin errs++; $display("FAIL reset_rsp0[%0d]: got %h/%h/%b want 0/0/00", c, f0.rsp_instr, f0.rsp_addr, f0.rsp_fault); end
    end
    f0.req_valid = 1'b0; f3.req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    cmp++; if (f0.rsp_valid !== 1'b0 || f3.rsp_valid !== 1'b0)
      begin errs++; $display("FAIL reset_no_accept: got %b%b want 00", f0.rsp_valid, f3.rsp_valid); end
    cmp++; if (f3.rsp_addr !== 32'h0) begin errs++; $display("FAIL reset_addr3: got %h want 0", f3.rsp_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] words [3] = '{32'h2000_0000, 32'h2001_0001, 32'h2002_0002};
    f0.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f0.req_valid = 1'b1; f0.req_addr = addrs[i];
      #1;
      cmp++; if (f0.req_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, f0.req_ready); end
      step();
      cmp++; if (f0.rsp_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, f0.rsp_valid); end
      cmp++; if (f0.rsp_instr !== words[i] || f0.rsp_addr !== addrs[i] || f0.rsp_fault !== 2'b00)
        begin errs++; $display("FAIL b2b_rsp[%0d]: got %h/%h/%b want %h/%h/00", i, f0.rsp_instr, f0.rsp_addr, f0.rsp_fault, words[i], addrs[i]); end
    end
    f0.req_valid = 1'b0;
    step();
    cmp++; if (f0.rsp_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain: got %b want 0", f0.rsp_valid); end
  endtask

  task automatic test_wait_states();
    f3.rsp_ready = 1'b1; f3.req_valid = 1'b1; f3.req_addr = 32'h10;
    step();
    f3.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp++; if (f3.rsp_valid !== 1'b0 || f3.req_ready !== 1'b0)
        begin errs++; $display("FAIL ws_wait[%0d]: valid/ready got %b/%b want 0/0", k, f3.rsp_valid, f3.req_ready); end
      step();
    end
    cmp++; if (f3.rsp_valid !== 1'b1) begin errs++; $display("FAIL ws_valid: got %b want 1", f3.rsp_valid); end
    cmp++; if (f3.rsp_instr !== 32'h2004_0004 || f3.rsp_addr !== 32'h10)
      begin errs++; $display("FAIL ws_rsp: got %h/%h want 20040004/00000010", f3.rsp_instr, f3.rsp_addr); end
    step();
    cmp++; if (f3.rsp_valid !== 1'b0) begin errs++; $display("FAIL ws_drain: got %b want 0", f3.rsp_valid); end
  endtask

  task automatic test_backpressure();
    f0.rsp_ready = 1'b0; f0.req_valid = 1'b1; f0.req_addr = 32'h20;
    step();
    f0.req_addr = 32'h24;
    for (int c = 0; c < 5; c++) begin
      #1;
      cmp++; if (f0.rsp_valid !== 1'b1 || f0.req_ready !== 1'b0)
        begin errs++; $display("FAIL bp_hold[%0d]: valid/ready got %b/%b want 1/0", c, f0.rsp_valid, f0.req_ready); end
      cmp++; if (f0.rsp_instr !== 32'h2008_0008 || f0.rsp_addr !== 32'h20 || f0.rsp_fault !== 2'b00)
        begin errs++; $display("FAIL bp_stable[%0d]: got %h/%h/%b want 20080008/00000020/00", c, f0.rsp_instr, f0.rsp_addr, f0.rsp_fault); end
      step();
    end
    f0.rsp_ready = 1'b1;
    #1;
    cmp++; if (f0.req_ready !== 1'b1) begin errs++; $display("FAIL bp_handoff_ready: got %b want 1", f0.req_ready); end
    step();
    f0.req_valid = 1'b0;
    cmp++; if (f0.rsp_valid !== 1'b1 || f0.rsp_instr !== 32'h2009_0009 || f0.rsp_addr !== 32'h24)
      begin errs++; $display("FAIL bp_next: got %b/%h/%h want 1/20090009/00000024", f0.rsp_valid, f0.rsp_instr, f0.rsp_addr); end
    step();
    cmp++; if (f0.rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_drain: got %b want 0", f0.rsp_valid); end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4] = '{32'h6, 32'h400, 32'h402, 32'h3FC};
    logic [1:0]  flts  [4] = '{2'b01, 2'b10, 2'b01, 2'b00};
    logic [31:0] words [4] = '{32'h0, 32'h0, 32'h0, 32'h20FF_00FF};
    f0.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f0.req_valid = 1'b1; f0.req_addr = addrs[i];
      step();
      cmp++; if (f0.rsp_valid !== 1'b1 || f0.rsp_fault !== flts[i] || f0.rsp_instr !== words[i] || f0.rsp_addr !== addrs[i])
        begin errs++; $display("FAIL fault[%0d]: got %b/%b/%h/%h want 1/%b/%h/%h", i, f0.rsp_valid, f0.rsp_fault, f0.rsp_instr, f0.rsp_addr, flts[i], words[i], addrs[i]); end
    end
    f0.req_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    // Flush while waiting: the aborted access must never respond.
    f3.rsp_ready = 1'b1; f3.req_valid = 1'b1; f3.req_addr = 32'h10;
    step();
    f3.req_valid = 1'b0;
    step();
    f3.flush = 1'b1;
    step();
    f3.flush = 1'b0;
    #1;
    cmp++; if (f3.rsp_valid !== 1'b0 || f3.req_ready !== 1'b1)
      begin errs++; $display("FAIL flush_wait: valid/ready got %b/%b want 0/1", f3.rsp_valid, f3.req_ready); end
    for (int c = 0; c < 5; c++) begin
      step();
      cmp++; if (f3.rsp_valid !== 1'b0) begin errs++; $display("FAIL flush_wait_stale[%0d]: got %b want 0", c, f3.rsp_valid); end
    end

    // Flush of a held response; request presented alongside is refused.
    f0.rsp_ready = 1'b0; f0.req_valid = 1'b1; f0.req_addr = 32'h8;
    step();
    f0.flush = 1'b1; f0.req_addr = 32'hC;
    #1;
    cmp++; if (f0.rsp_valid !== 1'b1 || f0.req_ready !== 1'b0)
      begin errs++; $display("FAIL flush_resp_pre: valid/ready got %b/%b want 1/0", f0.rsp_valid, f0.req_ready); end
    step();
    f0.flush = 1'b0; f0.req_valid = 1'b0; f0.rsp_ready = 1'b1;
    cmp++; if (f0.rsp_valid !== 1'b0 || f0.rsp_addr !== 32'h8)
      begin errs++; $display("FAIL flush_resp: valid/addr got %b/%h want 0/00000008", f0.rsp_valid, f0.rsp_addr); end
    step();
    cmp++; if (f0.rsp_valid !== 1'b0) begin errs++; $display("FAIL flush_resp_stale: got %b want 0", f0.rsp_valid); end

    // Flush in IDLE with a request pending.
    f0.flush = 1'b1; f0.req_valid = 1'b1; f0.req_addr = 32'h4;
    #1;
    cmp++; if (f0.req_ready !== 1'b0) begin errs++; $display("FAIL flush_idle_ready: got %b want 0", f0.req_ready); end
    step();
    f0.flush = 1'b0; f0.req_valid = 1'b0;
    step();
    cmp++; if (f0.rsp_valid !== 1'b0) begin errs++; $display("FAIL flush_idle_rsp: got %b want 0", f0.rsp_valid); end

    // Reset during WAIT abandons the access.
    f3.req_valid = 1'b1; f3.req_addr = 32'h14;
    step();
    f3.req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cmp++; if (f3.rsp_valid !== 1'b0 || f3.rsp_addr !== 32'h0)
      begin errs++; $display("FAIL rst_wait: valid/addr got %b/%h want 0/00000000", f3.rsp_valid, f3.rsp_addr); end
    for (int c = 0; c < 5; c++) begin
      step();
      cmp++; if (f3.rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_wait_stale[%0d]: got %b want 0", c, f3.rsp_valid); end
    end
  endtask

  initial begin
    f0.req_valid = 1'b0; f0.req_addr = 32'h0; f0.flush = 1'b0; f0.rsp_ready = 1'b0;
    f3.req_valid = 1'b0; f3.req_addr = 32'h0; f3.flush = 1'b0; f3.rsp_ready = 1'b0;
    #2;
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_backpressure();
    test_faults();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
